game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter SCREEN_W, default 800, visible width in pixels.
REQ-002 The block SHALL have parameter PIPE_SPEED, default 2, pixels moved per frame tick.
REQ-003 The block SHALL have parameter PIPE_SPACING, default 280, x distance between consecutive pipes.
REQ-004 The block SHALL have parameter GAP_H, default 160, vertical gap height (y2 - y1).
REQ-005 The block SHALL have parameter GROUND_Y, default 560, bird y at or below which the bird has hit the ground.
REQ-006 The block SHALL have parameter DIE_FRAMES, default 60, frame ticks spent in DYING.
REQ-007 The block SHALL have port clk, input, 1, the single system clock.
REQ-008 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-009 The block SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-010 The block SHALL have port btn_flap, input, 1, debounced flap button level.
REQ-011 The block SHALL have port crash, input, 1, sticky collision flag from the collision checker.
REQ-012 The block SHALL have port bird_y, input, 12, bird centre y.
REQ-013 The block SHALL have port game_state, output, 2, encoded as IDLE=0, PLAY=1, DYING=2, OVER=3.
REQ-014 The block SHALL have port play_en, output, 1, high only in PLAY; gates bird physics.
REQ-015 The block SHALL have port flap_pulse, output, 1, one-cycle jump command to bird physics.
REQ-016 The block SHALL have port clr_game, output, 1, one-cycle clear to the score and collision logic.
REQ-017 The block SHALL have ports pipk_x, output, 12, for k=0..2, pipe k centre x.
REQ-018 The block SHALL have ports pipk_y1 and pipk_y2, output, 12 each, for k=0..2, gap top and gap bottom.

Function
REQ-019 The block SHALL detect a btn_flap rising edge from a registered copy of btn_flap; all transitions use only this edge.
REQ-020 In IDLE, a flap edge SHALL move the FSM to PLAY and assert flap_pulse in the same cycle.
REQ-021 In PLAY, crash=1 or bird_y>=GROUND_Y SHALL move the FSM to DYING on the next clock; if this coincides with a flap edge, the move to DYING wins and flap_pulse is suppressed.
REQ-022 In PLAY, a flap edge without crash or ground contact SHALL assert flap_pulse for exactly one cycle.
REQ-023 In DYING, a 6-bit frame counter (cleared on entry) SHALL count frame_ticks, and the FSM SHALL move to OVER on the tick that makes the count DIE_FRAMES.
REQ-024 In OVER, a flap edge SHALL move the FSM to IDLE, assert clr_game for one cycle and reload all pipes to their initial values.
REQ-025 The initial values for pipe k SHALL be x = SCREEN_W + 40 + k*PIPE_SPACING (840, 1120, 1400), y1 = 200 and y2 = 360.
REQ-026 Pipes SHALL move only in PLAY on frame_tick: x_next = x - PIPE_SPEED; if x_next < 40, then x_next = x_next + 3*PIPE_SPACING.
REQ-027 On the tick a pipe wraps, its y1 SHALL become 80 + lfsr[7:0] (range 80..335) and its y2 SHALL become y1 + GAP_H, from the same LFSR sample.
REQ-028 If two pipes wrap on the same tick, they SHALL use lfsr[7:0] and lfsr[15:8] respectively, lower pipe index first.
REQ-029 The 16-bit LFSR SHALL use taps 16,14,13,11, seed 16'hACE1, and advance every clock in every state.
REQ-030 In IDLE, DYING and OVER, pipe positions SHALL hold.
REQ-031 play_en SHALL be a registered decode of state, with one-cycle latency from the state change.

Reset
REQ-032 While rst=0, the block SHALL set state=IDLE, play_en=0, flap_pulse=0, clr_game=0, the edge register to 1 (no spurious edge), the LFSR to its seed and the pipes to their initial values.
REQ-033 Reset asserted mid-PLAY or mid-DYING SHALL take effect immediately, with no pending pulse emitted after release.

Structure
REQ-034 A shared package game_pkg SHALL hold the state enum, the screen and pipe constants and the 12-bit coordinate typedef.
REQ-035 The LFSR SHALL be a sub-module named pipe_lfsr16, with ports clk, rst and a 16-bit value output.

Verification
REQ-036 After reset, the bench SHALL apply a btn_flap rise and check: game_state 0->1, flap_pulse high one cycle, pip0_x=840.
REQ-037 In PLAY, the bench SHALL apply 400 frame_ticks and check that pipe 0 goes 840->40 and that the next tick wraps it to 878 with y2-y1=160 and y1 in 80..335.
REQ-038 In PLAY, the bench SHALL raise crash and btn_flap in the same cycle and check: state=DYING next, no flap_pulse, pipes frozen.
REQ-039 In PLAY, the bench SHALL set bird_y=560 and check DYING, then OVER exactly on the 60th frame_tick.
REQ-040 In OVER, the bench SHALL apply a flap and check: clr_game for one cycle, state=IDLE, pipes at 840, 1120 and 1400 with y=200/360.
REQ-041 The bench SHALL assert rst mid-DYING and check that all outputs reach their reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, coordinate type and pipe constants
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  typedef logic [11:0] coord_t;

  localparam int SCREEN_W_DEF     = 800;
  localparam int PIPE_SPEED_DEF   = 2;
  localparam int PIPE_SPACING_DEF = 280;
  localparam int GAP_H_DEF        = 160;
  localparam int GROUND_Y_DEF     = 560;
  localparam int DIE_FRAMES_DEF   = 60;

  localparam int NUM_PIPES    = 3;
  localparam int PIPE_MIN_X   = 40;
  localparam int PIPE_Y_BASE  = 80;
  localparam int PIPE_Y1_INIT = 200;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Starting x of pipe k: just off the right edge, spaced evenly.
  function automatic coord_t pipe_x_init(input int screen_w, input int spacing, input int k);
    return coord_t'(screen_w + PIPE_MIN_X + k * spacing);
  endfunction

endpackage

// File: rtl/pipe_lfsr16.sv
// rtl/pipe_lfsr16.sv - free-running 16-bit Fibonacci LFSR for pipe gap heights
module pipe_lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  logic [15:0] lfsr_q, lfsr_d;

  // Shift left, feedback from taps 16,14,13,11.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Advances every clock regardless of game state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - game state machine and scrolling pipe positions
module game_sequencer
  import game_pkg::*;
#(
  parameter int SCREEN_W     = SCREEN_W_DEF,
  parameter int PIPE_SPEED   = PIPE_SPEED_DEF,
  parameter int PIPE_SPACING = PIPE_SPACING_DEF,
  parameter int GAP_H        = GAP_H_DEF,
  parameter int GROUND_Y     = GROUND_Y_DEF,
  parameter int DIE_FRAMES   = DIE_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_flap,
  input  logic        crash,
  input  logic [11:0] bird_y,
  output logic [1:0]  game_state,
  output logic        play_en,
  output logic        flap_pulse,
  output logic        clr_game,
  output logic [11:0] pip0_x,
  output logic [11:0] pip0_y1,
  output logic [11:0] pip0_y2,
  output logic [11:0] pip1_x,
  output logic [11:0] pip1_y1,
  output logic [11:0] pip1_y2,
  output logic [11:0] pip2_x,
  output logic [11:0] pip2_y1,
  output logic [11:0] pip2_y2
);

  state_e      state_q, state_d;
  logic        btn_q, btn_d;
  logic        play_en_q, play_en_d;
  logic        flap_pulse_q, flap_pulse_d;
  logic        clr_game_q, clr_game_d;
  logic [5:0]  die_cnt_q, die_cnt_d;
  coord_t      x_q  [NUM_PIPES];
  coord_t      x_d  [NUM_PIPES];
  coord_t      y1_q [NUM_PIPES];
  coord_t      y1_d [NUM_PIPES];
  coord_t      y2_q [NUM_PIPES];
  coord_t      y2_d [NUM_PIPES];
  logic [15:0] lfsr;
  logic        flap_edge;
  logic        hit;
  logic        reload;
  coord_t      nx;
  logic [7:0]  sample;
  logic        lfsr_used;

  pipe_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  assign flap_edge = btn_flap & ~btn_q;
  assign hit       = crash | (bird_y >= coord_t'(GROUND_Y));

  // Next state and one-cycle command pulses; dying beats a simultaneous flap.
  always_comb begin
    state_d      = state_q;
    die_cnt_d    = die_cnt_q;
    flap_pulse_d = 1'b0;
    clr_game_d   = 1'b0;
    reload       = 1'b0;
    btn_d        = btn_flap;
    play_en_d    = (state_q == ST_PLAY);
    case (state_q)
      ST_IDLE: begin
        if (flap_edge) begin
          state_d      = ST_PLAY;
          flap_pulse_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (hit) begin
          state_d   = ST_DYING;
          die_cnt_d = '0;
        end else if (flap_edge) begin
          flap_pulse_d = 1'b1;
        end
      end
      ST_DYING: begin
        if (frame_tick) begin
          die_cnt_d = die_cnt_q + 6'd1;
          if (die_cnt_q == 6'(DIE_FRAMES - 1)) state_d = ST_OVER;
        end
      end
      ST_OVER: begin
        if (flap_edge) begin
          state_d    = ST_IDLE;
          clr_game_d = 1'b1;
          reload     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pipe scroll and wrap; simultaneous wraps take successive LFSR bytes.
  always_comb begin
    x_d       = x_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    nx        = '0;
    sample    = '0;
    lfsr_used = 1'b0;
    if (reload) begin
      for (int k = 0; k < NUM_PIPES; k++) begin
        x_d[k]  = pipe_x_init(SCREEN_W, PIPE_SPACING, k);
        y1_d[k] = coord_t'(PIPE_Y1_INIT);
        y2_d[k] = coord_t'(PIPE_Y1_INIT + GAP_H);
      end
    end else if (state_q == ST_PLAY && frame_tick) begin
      for (int k = 0; k < NUM_PIPES; k++) begin
        nx = x_q[k] - coord_t'(PIPE_SPEED);
        if (nx < coord_t'(PIPE_MIN_X)) begin
          nx        = nx + coord_t'(NUM_PIPES * PIPE_SPACING);
          sample    = lfsr_used ? lfsr[15:8] : lfsr[7:0];
          lfsr_used = 1'b1;
          y1_d[k]   = coord_t'(PIPE_Y_BASE) + coord_t'(sample);
          y2_d[k]   = coord_t'(PIPE_Y_BASE) + coord_t'(sample) + coord_t'(GAP_H);
        end
        x_d[k] = nx;
      end
    end
  end

  // State, edge detector, pulses and pipe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      btn_q        <= 1'b1;
      play_en_q    <= 1'b0;
      flap_pulse_q <= 1'b0;
      clr_game_q   <= 1'b0;
      die_cnt_q    <= '0;
      for (int k = 0; k < NUM_PIPES; k++) begin
        x_q[k]  <= pipe_x_init(SCREEN_W, PIPE_SPACING, k);
        y1_q[k] <= coord_t'(PIPE_Y1_INIT);
        y2_q[k] <= coord_t'(PIPE_Y1_INIT + GAP_H);
      end
    end else begin
      state_q      <= state_d;
      btn_q        <= btn_d;
      play_en_q    <= play_en_d;
      flap_pulse_q <= flap_pulse_d;
      clr_game_q   <= clr_game_d;
      die_cnt_q    <= die_cnt_d;
      x_q          <= x_d;
      y1_q         <= y1_d;
      y2_q         <= y2_d;
    end
  end

  assign game_state = state_q;
  assign play_en    = play_en_q;
  assign flap_pulse = flap_pulse_q;
  assign clr_game   = clr_game_q;
  assign pip0_x     = x_q[0];
  assign pip0_y1    = y1_q[0];
  assign pip0_y2    = y2_q[0];
  assign pip1_x     = x_q[1];
  assign pip1_y1    = y1_q[1];
  assign pip1_y2    = y2_q[1];
  assign pip2_x     = x_q[2];
  assign pip2_y1    = y1_q[2];
  assign pip2_y2    = y2_q[2];

endmodule
